// File: rtl/ft_tx_writer.sv
`default_nettype none
// ============================================================================
// Module   : ft_tx_writer
// Brief    : FT245 synchronous-FIFO transmit path: byte FIFO, bus request,
//            zero-bubble burst writes gated by TXE#, SIWU# flush after idle.
// Revision : 1.0 - initial release
// ============================================================================
module ft_tx_writer #(
    parameter int DEPTH      = 16,
    parameter int FLUSH_IDLE = 64
) (
    input  logic                   ft_clk,
    input  logic                   rst_n,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_req,
    input  logic                   tx_grant,
    input  logic                   ft_txen,
    output logic                   ft_wrn,
    output logic [7:0]             ft_data_out,
    output logic                   ft_data_oe,
    output logic                   ft_siwu,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int   c_AW       = $clog2(DEPTH);
    localparam int   c_LW       = c_AW + 1;
    localparam int   c_CW       = (FLUSH_IDLE > 1) ? $clog2(FLUSH_IDLE + 1) : 1;
    localparam logic c_FLUSH_EN = (FLUSH_IDLE != 0);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_TURN    = 3'd1;
    localparam logic [2:0] c_WRITE   = 3'd2;
    localparam logic [2:0] c_RELEASE = 3'd3;
    localparam logic [2:0] c_FLUSH   = 3'd4;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_tx_ready, r_tx_req;
    logic [2:0]      r_state;
    logic            r_wrn, r_siwu, r_oe;
    logic [7:0]      r_dout;
    logic [c_CW-1:0] r_cnt;
    logic            r_armed, r_flush_pending;

    logic            w_push, w_accept, w_expire, w_clr_pending;
    logic [c_AW-1:0] w_rd_nxt_ptr;
    logic [7:0]      w_head, w_next_head;
    logic [c_LW-1:0] w_level_nxt;
    logic [2:0]      w_state_nxt;
    logic            w_wrn_nxt, w_siwu_nxt, w_oe_nxt;
    logic [7:0]      w_dout_nxt;

    assign w_push       = tx_valid && r_tx_ready;
    assign w_accept     = (r_state == c_WRITE) && !r_wrn && !ft_txen;
    assign w_rd_nxt_ptr = r_rd_ptr + c_AW'(1);
    // With one byte left, the byte following the head may be arriving this edge.
    assign w_head       = (r_level != '0) ? r_mem[r_rd_ptr] : tx_data;
    assign w_next_head  = (r_level > c_LW'(1)) ? r_mem[w_rd_nxt_ptr] : tx_data;
    assign w_expire     = r_armed && (r_cnt == '0) && !w_accept && !w_push;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_accept})
            2'b10:   w_level_nxt = r_level + c_LW'(1);
            2'b01:   w_level_nxt = r_level - c_LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wrn_nxt     = 1'b1;
        w_siwu_nxt    = 1'b1;
        w_oe_nxt      = r_oe;
        w_dout_nxt    = r_dout;
        w_clr_pending = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_tx_req && tx_grant) begin
                    w_state_nxt = c_TURN;
                    w_oe_nxt    = 1'b1;
                    w_dout_nxt  = w_head;
                end
            end
            c_TURN: begin
                w_clr_pending = 1'b1;
                if (!tx_grant) begin
                    w_state_nxt = c_RELEASE;
                end else if (r_level != '0) begin
                    w_state_nxt = c_WRITE;
                    w_dout_nxt  = w_head;
                    w_wrn_nxt   = ft_txen;
                end else begin
                    w_state_nxt = c_FLUSH;
                    w_siwu_nxt  = 1'b0;
                end
            end
            c_WRITE: begin
                if (w_accept) begin
                    w_dout_nxt = w_next_head;
                end
                if (!tx_grant || (w_accept && (w_level_nxt == '0))) begin
                    w_state_nxt = c_RELEASE;
                end else begin
                    w_wrn_nxt = ft_txen;
                end
            end
            c_FLUSH: begin
                w_state_nxt = c_RELEASE;
            end
            c_RELEASE: begin
                w_state_nxt = c_IDLE;
                w_oe_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_oe_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ft_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge ft_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_wrn      <= 1'b1;
            r_siwu     <= 1'b1;
            r_oe       <= 1'b0;
            r_dout     <= 8'h00;
            r_level    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_ready <= 1'b0;
            r_tx_req   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wrn      <= w_wrn_nxt;
            r_siwu     <= w_siwu_nxt;
            r_oe       <= w_oe_nxt;
            r_dout     <= w_dout_nxt;
            r_level    <= w_level_nxt;
            r_tx_ready <= (w_level_nxt != c_LW'(DEPTH));
            r_tx_req   <= (r_level != '0) || r_flush_pending;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_accept) begin
                r_rd_ptr <= w_rd_nxt_ptr;
            end
        end
    end

    // Idle timer: armed by an accept, cancelled by a push, fires once.
    always_ff @(posedge ft_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_armed         <= 1'b0;
            r_flush_pending <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= c_CW'(FLUSH_IDLE);
                r_armed <= c_FLUSH_EN;
            end else if (w_push) begin
                r_armed <= 1'b0;
            end else if (r_armed) begin
                if (r_cnt == '0) begin
                    r_armed <= 1'b0;
                end else if ((r_level == '0) && (r_state == c_IDLE)) begin
                    r_cnt <= r_cnt - c_CW'(1);
                end
            end
            if (w_clr_pending) begin
                r_flush_pending <= 1'b0;
            end else if (w_expire) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign tx_req      = r_tx_req;
    assign ft_wrn      = r_wrn;
    assign ft_siwu     = r_siwu;
    assign ft_data_oe  = r_oe;
    assign ft_data_out = r_dout;
    assign fifo_level  = r_level;

endmodule
`default_nettype wire

// File: tb/tb_ft_tx_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft_tx_writer
// Brief    : Directed/randomized bench for ft_tx_writer with a byte-order
//            scoreboard and a chip-side capture monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft_tx_writer;

    localparam int DEPTH      = 16;
    localparam int FLUSH_IDLE = 64;

    logic       ft_clk   = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_grant = 1'b0;
    logic       ft_txen  = 1'b1;
    logic       tx_ready, tx_req, ft_wrn, ft_data_oe, ft_siwu;
    logic [7:0] ft_data_out;
    logic [$clog2(DEPTH):0] fifo_level;

    ft_tx_writer #(.DEPTH(DEPTH), .FLUSH_IDLE(FLUSH_IDLE)) dut (
        .ft_clk      (ft_clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_req      (tx_req),
        .tx_grant    (tx_grant),
        .ft_txen     (ft_txen),
        .ft_wrn      (ft_wrn),
        .ft_data_out (ft_data_out),
        .ft_data_oe  (ft_data_oe),
        .ft_siwu     (ft_siwu),
        .fifo_level  (fifo_level)
    );

    always #5 ft_clk = ~ft_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cap_cnt = 0;
    int cap_cyc[$];
    int wrn_low_cnt = 0, oe_cnt = 0, siwu_cnt = 0, siwu_cyc = 0;
    logic [7:0] model_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Chip side: a byte is taken at any edge where WR# and TXE# are both low.
    always @(posedge ft_clk) begin
        cyc++;
        if (rst_n) begin
            if (tx_valid && tx_ready) model_q.push_back(tx_data);
            if (!ft_wrn && !ft_txen) begin
                cap_cnt++;
                cap_cyc.push_back(cyc);
                if (model_q.size() == 0) chk("cap_underflow", model_q.size(), 1);
                else chk("cap_data", int'(ft_data_out), int'(model_q.pop_front()));
            end
            if (!ft_wrn) wrn_low_cnt++;
            if (ft_data_oe) oe_cnt++;
            if (!ft_siwu) begin
                siwu_cnt++;
                siwu_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ft_clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        logic ok;
        logic done;
        done     = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            ok = tx_ready;
            tick();
            done = ok;
        end
        tx_valid = 1'b0;
        chk("push_done", int'(done), 1);
    endtask

    task automatic wait_caps(input int n, input int bound);
        for (int k = 0; k < bound && cap_cnt < n; k++) tick();
        chk("cap_count", cap_cnt, n);
    endtask

    task automatic wait_siwu();
        for (int k = 0; k < 200 && siwu_cnt == 0; k++) tick();
        tick(20);
        chk("siwu_pulses", siwu_cnt, 1);
    endtask

    initial begin
        int base, pcyc, gcyc, d;

        // Reset values
        tick(2);
        chk("rst_wrn", int'(ft_wrn), 1);
        chk("rst_siwu", int'(ft_siwu), 1);
        chk("rst_oe", int'(ft_data_oe), 0);
        chk("rst_dout", int'(ft_data_out), 0);
        chk("rst_req", int'(tx_req), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ready", int'(tx_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", int'(tx_ready), 1);

        // Single byte: four-edge latency, one WR# cycle, three OE cycles, one flush
        tx_grant = 1'b1;
        ft_txen  = 1'b0;
        tick(2);
        wrn_low_cnt = 0; oe_cnt = 0; siwu_cnt = 0;
        base = cap_cnt;
        push(8'hA5);
        pcyc = cyc;
        wait_caps(base + 1, 20);
        chk("single_latency", cap_cyc[$] - pcyc, 4);
        tick(10);
        chk("single_wrn_cycles", wrn_low_cnt, 1);
        chk("single_oe_cycles", oe_cnt, 3);
        chk("single_no_early_siwu", siwu_cnt, 0);
        wait_siwu();
        d = siwu_cyc - cap_cyc[$];
        chk("siwu_window", int'(d >= FLUSH_IDLE && d <= FLUSH_IDLE + 12), 1);
        tick(100);
        chk("siwu_once", siwu_cnt, 1);
        chk("single_oe_idle", int'(ft_data_oe), 0);

        // Fill to full without grant, then one 16-byte burst
        tx_grant = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("full_level", int'(fifo_level), DEPTH);
        chk("full_ready", int'(tx_ready), 0);
        tx_data = 8'hEE; tx_valid = 1'b1;
        tick(3);
        tx_valid = 1'b0;
        chk("full_no_overflow", int'(fifo_level), DEPTH);
        siwu_cnt = 0;
        base = cap_cnt;
        cap_cyc.delete();
        tx_grant = 1'b1;
        wait_caps(base + 16, 80);
        chk("burst_consecutive", cap_cyc[15] - cap_cyc[0], 15);
        tick(2);
        chk("burst_level_empty", int'(fifo_level), 0);
        wait_siwu();

        // TXE# stall for five cycles after byte 0x06
        tx_grant = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        siwu_cnt = 0;
        base = cap_cnt;
        tx_grant = 1'b1;
        wait_caps(base + 7, 60);
        ft_txen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_wrn_high", int'(ft_wrn), 1);
        end
        chk("stall_no_capture", cap_cnt, base + 7);
        ft_txen = 1'b0;
        wait_caps(base + 16, 60);
        wait_siwu();
        chk("stall_model_empty", model_q.size(), 0);

        // Grant withdrawn while the 4th byte is on the bus (WR# already low)
        tx_grant = 1'b0;
        for (int i = 0; i < 16; i++) push(8'($urandom));
        siwu_cnt = 0;
        base = cap_cnt;
        tx_grant = 1'b1;
        wait_caps(base + 3, 60);
        tx_grant = 1'b0;
        tick(2);
        chk("drop_oe_low", int'(ft_data_oe), 0);
        tick(5);
        chk("drop_caps", cap_cnt, base + 4);
        chk("drop_level", int'(fifo_level), 12);
        gcyc = cyc;
        tx_grant = 1'b1;
        wait_caps(base + 5, 20);
        chk("regrant_turn_latency", cap_cyc[$] - gcyc, 3);
        wait_caps(base + 16, 60);
        wait_siwu();

        // Steady stream at one byte per clock around level 8
        ft_txen = 1'b1;
        for (int i = 0; i < 7; i++) push(8'($urandom));
        chk("stream_prefill", int'(fifo_level), 7);
        ft_txen  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        tick();
        for (int i = 0; i < 20; i++) begin
            tx_data = 8'($urandom);
            tick();
            chk("stream_level", int'(fifo_level), 8);
            chk("stream_ready", int'(tx_ready), 1);
        end
        tx_valid = 1'b0;
        siwu_cnt = 0;
        for (int k = 0; k < 60 && model_q.size() != 0; k++) tick();
        chk("stream_drained", model_q.size(), 0);
        wait_siwu();

        // Reset in the middle of a burst
        tx_grant = 1'b0;
        for (int i = 0; i < 16; i++) push(8'($urandom));
        siwu_cnt = 0;
        base = cap_cnt;
        tx_grant = 1'b1;
        wait_caps(base + 5, 60);
        rst_n = 1'b0;
        model_q.delete();
        #1;
        chk("midrst_wrn", int'(ft_wrn), 1);
        chk("midrst_oe", int'(ft_data_oe), 0);
        chk("midrst_level", int'(fifo_level), 0);
        tick();
        rst_n = 1'b1;
        tick(150);
        chk("midrst_no_siwu", siwu_cnt, 0);
        base = cap_cnt;
        push(8'($urandom));
        wait_caps(base + 1, 20);
        chk("postrst_model_empty", model_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
